// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId, exception/interrupt request, mfc0/mtc0, eret.
// Optional macro CP0_BADVADDR_EN adds input BadAddrIn and the read-only BadVAddr register (reg 8).
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h2022_0701,
    parameter int          HWINT_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [4:0]         CP0Addr,
    input  logic [31:0]        CP0In,
    output logic [31:0]        CP0Out,
    input  logic [31:0]        VPC,
    input  logic               BDIn,
    input  logic [4:0]         ExcCodeIn,
    input  logic [HWINT_W-1:0] HWInt,
    input  logic               EXLClr,
    output logic [31:0]        EPCOut,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0]        BadAddrIn,
`endif
    output logic               Req
);

    logic [HWINT_W-1:0] im;
    logic               exl;
    logic               ie;
    logic               bd;
    logic [HWINT_W-1:0] ip;
    logic [4:0]         exc_code;
    logic [31:0]        epc;
`ifdef CP0_BADVADDR_EN
    logic [31:0]        badvaddr;
`endif

    logic               int_req;
    logic               exc_req;
    logic [31:0]        sr_val;
    logic [31:0]        cause_val;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

    // Requests are judged against the live interrupt lines, not the latched Cause.IP.
    assign int_req = (|(HWInt & im)) & ie & ~exl;
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
    assign Req     = ~reset & (int_req | exc_req);
    assign EPCOut  = epc;

    always_comb begin
        sr_val                 = '0;
        sr_val[10 +: HWINT_W]  = im;
        sr_val[1]              = exl;
        sr_val[0]              = ie;
        cause_val              = '0;
        cause_val[31]          = bd;
        cause_val[10 +: HWINT_W] = ip;
        cause_val[6:2]         = exc_code;
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Addr)
            5'd12:   CP0Out = sr_val;
            5'd13:   CP0Out = cause_val;
            5'd14:   CP0Out = epc;
            5'd15:   CP0Out = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
            5'd8:    CP0Out = badvaddr;
`endif
            default: CP0Out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
`ifdef CP0_BADVADDR_EN
            badvaddr <= '0;
`endif
        end else begin
            ip <= HWInt;
            if (Req) begin
                // A taken request overrides any mtc0 or eret in the same cycle.
                exl      <= 1'b1;
                bd       <= BDIn;
                exc_code <= int_req ? 5'd0 : ExcCodeIn;
                epc      <= word_align(BDIn ? VPC - 32'd4 : VPC);
`ifdef CP0_BADVADDR_EN
                if (!int_req && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5))
                    badvaddr <= BadAddrIn;
`endif
            end else begin
                if (en) begin
                    case (CP0Addr)
                        5'd12: begin
                            im  <= CP0In[10 +: HWINT_W];
                            exl <= CP0In[1];
                            ie  <= CP0In[0];
                        end
                        5'd14:   epc <= word_align(CP0In);
                        default: ;
                    endcase
                end
                if (EXLClr)
                    exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: driver pushes model expectations each cycle, monitor pops and compares.
// Build with CP0_BADVADDR_EN defined to also exercise BadVAddr.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h2022_0701;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [4:0]  CP0Addr = '0;
    logic [31:0] CP0In = '0;
    logic [31:0] CP0Out;
    logic [31:0] VPC = '0;
    logic        BDIn = 1'b0;
    logic [4:0]  ExcCodeIn = '0;
    logic [5:0]  HWInt = '0;
    logic        EXLClr = 1'b0;
    logic [31:0] EPCOut;
    logic [31:0] BadAddrIn = '0;
    logic        Req;

    always #5 clk = ~clk;

    cp0_unit #(.PRID_VALUE(PRID), .HWINT_W(6)) dut (
        .clk(clk), .reset(reset), .en(en), .CP0Addr(CP0Addr), .CP0In(CP0In),
        .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut),
`ifdef CP0_BADVADDR_EN
        .BadAddrIn(BadAddrIn),
`endif
        .Req(Req)
    );

    typedef struct {
        int          cyc;
        logic        req;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    // Architectural model: whole 32-bit register images as software would see them.
    logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0, m_bad = '0;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return PRID;
`ifdef CP0_BADVADDR_EN
            5'd8:  return m_bad;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [4:0] addr,
                         input logic [31:0] din, input logic [31:0] pc, input logic bdi,
                         input logic [4:0] exc, input logic [5:0] hw, input logic clr,
                         input logic [31:0] bad);
        logic ireq, ereq, req;
        exp_t e;
        reset = rst; en = we; CP0Addr = addr; CP0In = din; VPC = pc; BDIn = bdi;
        ExcCodeIn = exc; HWInt = hw; EXLClr = clr; BadAddrIn = bad;
        ireq = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        ereq = (exc != 5'd0) && !m_sr[1];
        req  = !rst && (ireq || ereq);
        e.cyc = cycle; e.req = req; e.rd = m_read(addr); e.epc = m_epc;
        exp_q.push_back(e);
        if (rst) begin
            m_sr = '0; m_cause = '0; m_epc = '0; m_bad = '0;
        end else begin
            m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
            if (req) begin
                m_sr    = m_sr | 32'h2;
                m_cause = (m_cause & 32'h0000_FC00) | ({31'd0, bdi} << 31)
                          | ({27'd0, (ireq ? 5'd0 : exc)} << 2);
                m_epc   = (bdi ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
                if (!ireq && (exc == 5'd4 || exc == 5'd5))
                    m_bad = bad;
            end else begin
                if (we && addr == 5'd12) m_sr  = din & 32'h0000_FC03;
                if (we && addr == 5'd14) m_epc = din & 32'hFFFF_FFFC;
                if (clr) m_sr = m_sr & ~32'h2;
            end
        end
        @(posedge clk); #1;
        cycle++;
    endtask

    task automatic rd(input logic [4:0] a, input logic [5:0] hw);
        drive(1'b0, 1'b0, a, 32'h0, 32'h0, 1'b0, 5'd0, hw, 1'b0, 32'h0);
    endtask

    task automatic eret();
        drive(1'b0, 1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 32'h0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 3;
            if (Req !== e.req) begin
                failures++;
                $display("FAIL req cycle=%0d got=%b exp=%b", e.cyc, Req, e.req);
            end
            if (CP0Out !== e.rd) begin
                failures++;
                $display("FAIL cp0out cycle=%0d addr=%0d got=%h exp=%h", e.cyc, CP0Addr, CP0Out, e.rd);
            end
            if (EPCOut !== e.epc) begin
                failures++;
                $display("FAIL epcout cycle=%0d got=%h exp=%h", e.cyc, EPCOut, e.epc);
            end
        end
    end

    initial begin
        logic [4:0] addrs [6];
        addrs[0] = 5'd8; addrs[1] = 5'd12; addrs[2] = 5'd13;
        addrs[3] = 5'd14; addrs[4] = 5'd15; addrs[5] = 5'd3;
        @(posedge clk); #1;
        // Reset with all interrupt lines high, then read SR/Cause/EPC/PRId.
        drive(1'b1, 1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd7, 6'h3F, 1'b0, 32'h0);
        rd(5'd12, 6'h3F); rd(5'd13, 6'h3F); rd(5'd14, 6'h3F); rd(5'd15, 6'h3F); rd(5'd8, 6'h0);
        // Interrupt: enable IM[0]/IE, raise HWInt[0].
        drive(1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 5'd13, 32'h0, 32'h3010, 1'b0, 5'd0, 6'h1, 1'b0, 32'h0);
        rd(5'd12, 6'h1); rd(5'd13, 6'h1); rd(5'd14, 6'h1);
        // Exception in a delay slot, then a masked second exception.
        eret();
        drive(1'b0, 1'b0, 5'd13, 32'h0, 32'h3024, 1'b1, 5'd10, 6'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 5'd13, 32'h0, 32'h3028, 1'b0, 5'd5, 6'h0, 1'b0, 32'h0);
        rd(5'd14, 6'h0);
        // mtc0 EPC colliding with Req, then without.
        eret();
        drive(1'b0, 1'b1, 5'd14, 32'h1234, 32'h4000, 1'b0, 5'd12, 6'h0, 1'b0, 32'h0);
        rd(5'd14, 6'h0);
        eret();
        drive(1'b0, 1'b1, 5'd14, 32'h1237, 32'h0, 1'b0, 5'd0, 6'h0, 1'b0, 32'h0);
        rd(5'd14, 6'h0);
        // Pending interrupt masked by EXL, released by eret.
        drive(1'b0, 1'b0, 5'd12, 32'h0, 32'h5000, 1'b0, 5'd8, 6'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 5'd12, 32'h0, 32'h5004, 1'b0, 5'd0, 6'h1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 5'd12, 32'h0, 32'h5008, 1'b0, 5'd0, 6'h1, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 5'd14, 32'h0, 32'h500C, 1'b0, 5'd0, 6'h1, 1'b0, 32'h0);
        rd(5'd13, 6'h0);
        // BadVAddr capture on AdEL, and no capture when an interrupt wins.
        eret();
        drive(1'b0, 1'b0, 5'd8, 32'h0, 32'h6000, 1'b0, 5'd4, 6'h0, 1'b0, 32'h7F01);
        rd(5'd8, 6'h0);
        eret();
        drive(1'b0, 1'b0, 5'd8, 32'h0, 32'h6010, 1'b0, 5'd4, 6'h1, 1'b0, 32'h1111);
        rd(5'd8, 6'h0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        r, we, clr;
            logic [4:0]  a, exc;
            logic [5:0]  hw;
            r   = ($urandom_range(0, 63) == 0);
            we  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 5) == 0);
            a   = ($urandom_range(0, 5) == 5) ? 5'($urandom) : addrs[$urandom_range(0, 4)];
            exc = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            if ($urandom_range(0, 3) == 0) exc = 5'($urandom_range(4, 5));
            hw  = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            drive(r, we, a, $urandom, $urandom, 1'($urandom), exc, hw, clr, $urandom);
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
